// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes ALUOp/funct3/funct7 into the ALU operation code and
// hands registered operands to execute through a two-entry skid buffer.
module alu_issue_stage #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    in_a,
    input  logic [DATA_WIDTH-1:0]    in_b,
    input  logic [1:0]               in_aluop,
    input  logic [2:0]               in_funct3,
    input  logic [6:0]               in_funct7,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     illegal
);

    localparam logic [OPCODE_LENGTH-1:0] OP_AND = OPCODE_LENGTH'(4'b0000);
    localparam logic [OPCODE_LENGTH-1:0] OP_SUB = OPCODE_LENGTH'(4'b0001);
    localparam logic [OPCODE_LENGTH-1:0] OP_ADD = OPCODE_LENGTH'(4'b0010);
    localparam logic [OPCODE_LENGTH-1:0] OP_OR  = OPCODE_LENGTH'(4'b0011);
    localparam logic [OPCODE_LENGTH-1:0] OP_XOR = OPCODE_LENGTH'(4'b0100);
    localparam logic [OPCODE_LENGTH-1:0] OP_SLT = OPCODE_LENGTH'(4'b0101);
    localparam logic [OPCODE_LENGTH-1:0] OP_EQ  = OPCODE_LENGTH'(4'b1000);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    // Returns {illegal, operation}; illegal beats carry the all-ones code.
    function automatic logic [OPCODE_LENGTH:0] decode(input logic [1:0] aluop,
                                                      input logic [2:0] f3,
                                                      input logic [6:0] f7);
        logic                     ill;
        logic [OPCODE_LENGTH-1:0] op;
        ill = 1'b0;
        op  = OP_ADD;
        case (aluop)
            2'b00: op = OP_ADD;
            2'b01: begin
                case (f3)
                    3'b000:  op = OP_EQ;
                    3'b001:  op = OP_SUB;
                    default: ill = 1'b1;
                endcase
            end
            default: begin
                if (aluop == 2'b10 && f7 != 7'b0000000 && f7 != 7'b0100000)
                    ill = 1'b1;
                else if (aluop == 2'b10 && f7[5] && f3 != 3'b000)
                    ill = 1'b1;
                else begin
                    case (f3)
                        3'b000:  op = (aluop == 2'b10 && f7[5]) ? OP_SUB : OP_ADD;
                        3'b111:  op = OP_AND;
                        3'b110:  op = OP_OR;
                        3'b100:  op = OP_XOR;
                        3'b010:  op = OP_SLT;
                        default: ill = 1'b1;
                    endcase
                end
            end
        endcase
        if (ill)
            op = '1;
        return {ill, op};
    endfunction

    state_t                   state, nxt;
    logic                     accept, consume;
    logic                     load_main, load_skid, skid_to_main;
    logic [OPCODE_LENGTH:0]   dec_p0;
    logic [DATA_WIDTH-1:0]    a_p1, b_p1, a_sk, b_sk;
    logic [OPCODE_LENGTH-1:0] op_p1, op_sk;
    logic                     ill_p1, ill_sk;

    // Stage p0: combinational decode of the incoming beat
    assign dec_p0  = decode(in_aluop, in_funct3, in_funct7);
    assign accept  = in_valid && in_ready;
    assign consume = out_valid && out_ready;

    always_comb begin
        nxt          = state;
        load_main    = 1'b0;
        load_skid    = 1'b0;
        skid_to_main = 1'b0;
        if (flush) begin
            nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        nxt       = ONE;
                        load_main = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && !consume) begin
                        nxt       = TWO;
                        load_skid = 1'b1;
                    end else if (accept) begin
                        load_main = 1'b1;
                    end else if (consume) begin
                        nxt = EMPTY;
                    end
                end
                TWO: begin
                    if (consume) begin
                        nxt          = ONE;
                        skid_to_main = 1'b1;
                    end
                end
                default: nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= nxt;
            in_ready <= (nxt != TWO);
        end
    end

    // Stage p1: main register feeds the ALU, skid catches the overflow beat
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_p1   <= '0;
            b_p1   <= '0;
            op_p1  <= '0;
            ill_p1 <= 1'b0;
            a_sk   <= '0;
            b_sk   <= '0;
            op_sk  <= '0;
            ill_sk <= 1'b0;
        end else begin
            if (load_main) begin
                a_p1   <= in_a;
                b_p1   <= in_b;
                op_p1  <= dec_p0[OPCODE_LENGTH-1:0];
                ill_p1 <= dec_p0[OPCODE_LENGTH];
            end else if (skid_to_main) begin
                a_p1   <= a_sk;
                b_p1   <= b_sk;
                op_p1  <= op_sk;
                ill_p1 <= ill_sk;
            end
            if (load_skid) begin
                a_sk   <= in_a;
                b_sk   <= in_b;
                op_sk  <= dec_p0[OPCODE_LENGTH-1:0];
                ill_sk <= dec_p0[OPCODE_LENGTH];
            end
        end
    end

    assign out_valid = (state != EMPTY);
    assign SrcA      = a_p1;
    assign SrcB      = b_p1;
    assign Operation = op_p1;
    assign illegal   = ill_p1;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a queue scoreboard of expected beats.
module tb_alu_issue_stage;

    logic        clk, reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_a, in_b, SrcA, SrcB;
    logic [1:0]  in_aluop;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [3:0]  Operation;
    logic        illegal;

    int n_checks = 0;
    int n_fail   = 0;
    logic [68:0] sb[$];

    alu_issue_stage #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_aluop(in_aluop),
        .in_funct3(in_funct3), .in_funct7(in_funct7),
        .out_valid(out_valid), .out_ready(out_ready),
        .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decode written as a table walk: returns {illegal, code}
    function automatic logic [4:0] model(input logic [1:0] aop, input logic [2:0] f3,
                                         input logic [6:0] f7);
        logic [3:0] r;
        r = 4'hF;
        if (aop == 2'd0) r = 4'h2;
        else if (aop == 2'd1) r = (f3 == 3'd0) ? 4'h8 : (f3 == 3'd1) ? 4'h1 : 4'hF;
        else if (aop == 2'd2 && !(f7 == 7'h00 || f7 == 7'h20)) r = 4'hF;
        else if (aop == 2'd2 && f7 == 7'h20) r = (f3 == 3'd0) ? 4'h1 : 4'hF;
        else begin
            case (f3)
                3'd0: r = 4'h2;
                3'd2: r = 4'h5;
                3'd4: r = 4'h4;
                3'd6: r = 4'h3;
                3'd7: r = 4'h0;
                default: r = 4'hF;
            endcase
        end
        return {(r == 4'hF), r};
    endfunction

    task automatic chk(input string tag, input logic [68:0] obs, input logic [68:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] aop, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b);
        in_valid = v; in_aluop = aop; in_funct3 = f3; in_funct7 = f7; in_a = a; in_b = b;
    endtask

    // Scoreboard: sampled mid-cycle, ahead of the edge that commits the transfer
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_beat", 69'(sb.size()), 69'd1);
                end else begin
                    chk("sb_beat", {SrcA, SrcB, illegal, Operation}, sb.pop_front());
                end
            end
            if (flush) sb.delete();
            else if (in_valid && in_ready)
                sb.push_back({in_a, in_b, model(in_aluop, in_funct3, in_funct7)});
        end
    end

    logic [31:0] pa, pb;

    initial begin
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 2'd0, 3'd0, 7'd0, 32'd0, 32'd0);
        step(); step();
        chk("rst_out_valid", 69'(out_valid), 69'd0);
        chk("rst_in_ready", 69'(in_ready), 69'd1);
        chk("rst_data", {SrcA, SrcB, illegal, Operation}, 69'd0);
        reset = 1'b0;
        step();

        // First beat: R-type SUB, visible one edge after acceptance
        drive(1'b1, 2'b10, 3'b000, 7'b0100000, 32'd7, 32'd3);
        step();
        in_valid = 1'b0;
        chk("sub_valid", 69'(out_valid), 69'd1);
        chk("sub_beat", {SrcA, SrcB, illegal, Operation}, {32'd7, 32'd3, 1'b0, 4'b0001});
        out_ready = 1'b1;
        step();
        chk("sub_drained", 69'(out_valid), 69'd0);

        // Undecodable R-type funct3 is forwarded with the all-ones code
        out_ready = 1'b0;
        drive(1'b1, 2'b10, 3'b101, 7'b0000000, 32'd11, 32'd12);
        step();
        in_valid = 1'b0;
        chk("illegal_beat", {illegal, Operation}, {64'd0, 5'b11111});
        out_ready = 1'b1;
        step();

        // Full decode sweep streamed back to back
        for (int aop = 0; aop < 4; aop++)
            for (int f3 = 0; f3 < 8; f3++)
                for (int fi = 0; fi < 3; fi++) begin
                    drive(1'b1, 2'(aop), 3'(f3), (fi == 0) ? 7'h00 : (fi == 1) ? 7'h20 : 7'h01,
                          $urandom, $urandom);
                    step();
                    chk("stream_in_ready", 69'(in_ready), 69'd1);
                    chk("stream_out_valid", 69'(out_valid), 69'd1);
                end
        in_valid = 1'b0;
        step();
        chk("stream_drained", 69'(out_valid), 69'd0);

        // Back-pressure: two beats fill the buffer, then drain in order
        out_ready = 1'b0;
        pa = 32'hA0A0_0001; pb = 32'hB0B0_0002;
        drive(1'b1, 2'b11, 3'b111, 7'd0, pa, 32'd1);
        step();
        chk("bp_one_ready", 69'(in_ready), 69'd1);
        drive(1'b1, 2'b11, 3'b110, 7'd0, pb, 32'd2);
        step();
        in_valid = 1'b0;
        chk("bp_two_ready", 69'(in_ready), 69'd0);
        chk("bp_hold_a", 69'(SrcA), 69'(pa));
        step(); step();
        chk("bp_still_a", {SrcA, SrcB, illegal, Operation}, {pa, 32'd1, 5'b00000});
        chk("bp_still_ready", 69'(in_ready), 69'd0);
        out_ready = 1'b1;
        step();
        chk("bp_b_main", 69'(SrcA), 69'(pb));
        chk("bp_ready_back", 69'(in_ready), 69'd1);
        step();
        chk("bp_empty", 69'(out_valid), 69'd0);

        // Flush in TWO with an incoming beat that must vanish
        out_ready = 1'b0;
        drive(1'b1, 2'b00, 3'b000, 7'd0, 32'd21, 32'd22);
        step();
        drive(1'b1, 2'b00, 3'b000, 7'd0, 32'd23, 32'd24);
        step();
        drive(1'b1, 2'b00, 3'b000, 7'd0, 32'd25, 32'd26);
        flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("flush_valid", 69'(out_valid), 69'd0);
        chk("flush_ready", 69'(in_ready), 69'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("flush_quiet", 69'(out_valid), 69'd0);
        end

        // Asynchronous reset between edges while streaming
        out_ready = 1'b0;
        drive(1'b1, 2'b11, 3'b100, 7'd0, 32'd31, 32'd32);
        step();
        drive(1'b1, 2'b11, 3'b010, 7'd0, 32'd33, 32'd34);
        step();
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", 69'(out_valid), 69'd0);
        chk("arst_ready", 69'(in_ready), 69'd1);
        chk("arst_data", {SrcA, SrcB, illegal, Operation}, 69'd0);
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        reset = 1'b0;
        step();
        chk("arst_after", 69'(out_valid), 69'd0);

        begin
            int budget;
            budget = 50;
            while (sb.size() != 0 && budget > 0) begin
                step();
                budget--;
            end
            chk("sb_empty_at_end", 69'(sb.size()), 69'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
